lcd_win_stat: RTL and testbench

Downstream stage of the LCD window controller. It consumes the 9-pixel (3x3) window burst, which arrives on the controller's dataout/output_valid pair. For each window it computes max, min, sum and floor average, then presents them behind a valid/ready handshake to the display-statistics consumer. The floor average comes from a multi-cycle restoring divider.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_win_stat_if.sv | 31 +++
 rtl/lcd_div_seq.sv | 63 ++++++
 rtl/lcd_win_stat.sv | 177 +++++++++++++++++
 tb/tb_lcd_win_stat.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared defaults, FSM state encoding and sum-width helper for the
//            LCD window statistics block.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int DW_DEF      = 8;
  localparam int PIX_NUM_DEF = 9;
  localparam int GAP_MAX_DEF = 4;

  // Bits needed to hold pix * (2^dw - 1) without overflow.
  function automatic int sum_width(input int dw, input int pix);
    return dw + $clog2(pix);
  endfunction

  localparam int SW_DEF = sum_width(DW_DEF, PIX_NUM_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_win_stat_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_win_stat_if
// Purpose  : Pixel stream input and result handshake of the window statistics
//            stage. master = pixel source / result consumer, slave = stat block.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_win_stat_if #(
  parameter int DW = 8,
  parameter int SW = 12
);
  logic [DW-1:0] datain;
  logic          in_valid;
  logic          res_ready;
  logic          res_valid;
  logic [DW-1:0] max_out;
  logic [DW-1:0] min_out;
  logic [SW-1:0] sum_out;
  logic [DW-1:0] avg_out;

  modport master (
    output datain, in_valid, res_ready,
    input  res_valid, max_out, min_out, sum_out, avg_out
  );

  modport slave (
    input  datain, in_valid, res_ready,
    output res_valid, max_out, min_out, sum_out, avg_out
  );
endinterface
`default_nettype wire

// File: rtl/lcd_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : lcd_div_seq
// Purpose  : Restoring shift-subtract divider, one quotient bit per cycle.
//            start loads the dividend; SW steps follow. done is high during
//            the final step and quotient then shows the completed result, so
//            the caller can latch it on that same edge.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_div_seq #(
  parameter int SW = 12
)(
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          start,
  input  wire logic [SW-1:0] dividend,
  input  wire logic [SW-1:0] divisor,
  output logic      [SW-1:0] quotient,
  output logic               done
);
  localparam int CW = $clog2(SW + 1);

  logic [SW-1:0] rem;
  logic [SW-1:0] q_reg;
  logic [CW-1:0] cnt;
  logic          running;

  logic [SW:0]   shifted;
  logic          ge;
  logic [SW-1:0] diff;
  logic [SW-1:0] rem_step;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {rem, q_reg[SW-1]};
    ge       = (shifted >= {1'b0, divisor});
    diff     = shifted[SW-1:0] - divisor;
    rem_step = ge ? diff : shifted[SW-1:0];
    quotient = {q_reg[SW-2:0], ge};
    done     = running && (cnt == CW'(1));
  end

  // Load on start, then shift one quotient bit in per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= '0;
      q_reg   <= dividend;
      cnt     <= CW'(SW);
      running <= 1'b1;
    end else if (running) begin
      rem   <= rem_step;
      q_reg <= quotient;
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/lcd_win_stat.sv
`default_nettype none
// ============================================================================
// Module   : lcd_win_stat
// Purpose  : Collects a PIX_NUM-pixel window, computes max/min/sum and the
//            floor average, and offers them behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_win_stat
  import lcd_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int PIX_NUM = PIX_NUM_DEF,
  parameter int SW      = sum_width(DW, PIX_NUM),
  parameter int GAP_MAX = GAP_MAX_DEF
)(
  input  wire logic     clk,
  input  wire logic     reset_n,
  lcd_win_stat_if.slave bus,
  output logic          busy,
  output logic          win_err,
  output logic          overrun
);
  localparam int PCW = $clog2(PIX_NUM + 1);
  localparam int GCW = $clog2(GAP_MAX + 1);
  localparam logic [PCW-1:0] LAST_PIX = PCW'(PIX_NUM - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP_MAX - 1);
  localparam logic [SW-1:0]  DIVISOR  = SW'(PIX_NUM);

  state_e state, state_nxt;

  logic [PCW-1:0] pix_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [SW-1:0]  sum_acc;
  logic [DW-1:0]  max_acc;
  logic [DW-1:0]  min_acc;

  logic           res_valid_r;
  logic [DW-1:0]  max_r;
  logic [DW-1:0]  min_r;
  logic [SW-1:0]  sum_r;
  logic [DW-1:0]  avg_r;

  logic [SW-1:0]  sum_add;
  logic [DW-1:0]  max_upd;
  logic [DW-1:0]  min_upd;

  logic           div_start;
  logic [SW-1:0]  div_dividend;
  logic [SW-1:0]  div_q;
  logic           div_done;

  // Running statistics including the pixel currently on datain.
  always_comb begin
    sum_add = sum_acc + SW'(bus.datain);
    max_upd = (bus.datain > max_acc) ? bus.datain : max_acc;
    min_upd = (bus.datain < min_acc) ? bus.datain : min_acc;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; the divider is started on the edge that enters DIV
  // with the sum that includes the final pixel.
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = sum_add;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (PIX_NUM == 1) begin
            state_nxt    = ST_DIV;
            div_start    = 1'b1;
            div_dividend = SW'(bus.datain);
          end else begin
            state_nxt = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (bus.in_valid) begin
          if (pix_cnt == LAST_PIX) begin
            state_nxt = ST_DIV;
            div_start = 1'b1;
          end
        end else if (gap_cnt == LAST_GAP) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV:  if (div_done)      state_nxt = ST_HOLD;
      ST_HOLD: if (bus.res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Accumulators, result registers and the one-cycle event pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt     <= '0;
      gap_cnt     <= '0;
      sum_acc     <= '0;
      max_acc     <= '0;
      min_acc     <= '0;
      res_valid_r <= 1'b0;
      max_r       <= '0;
      min_r       <= '0;
      sum_r       <= '0;
      avg_r       <= '0;
      win_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      win_err <= 1'b0;
      overrun <= bus.in_valid && busy;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sum_acc <= SW'(bus.datain);
            max_acc <= bus.datain;
            min_acc <= bus.datain;
            pix_cnt <= PCW'(1);
            gap_cnt <= '0;
          end
        end
        ST_ACC: begin
          if (bus.in_valid) begin
            sum_acc <= sum_add;
            max_acc <= max_upd;
            min_acc <= min_upd;
            pix_cnt <= pix_cnt + PCW'(1);
            gap_cnt <= '0;
          end else if (gap_cnt == LAST_GAP) begin
            win_err <= 1'b1;
            sum_acc <= '0;
            max_acc <= '0;
            min_acc <= '0;
            pix_cnt <= '0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        ST_DIV: begin
          if (div_done) begin
            max_r       <= max_acc;
            min_r       <= min_acc;
            sum_r       <= sum_acc;
            avg_r       <= DW'(div_q);
            res_valid_r <= 1'b1;
          end
        end
        ST_HOLD: if (bus.res_ready) res_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy          = (state == ST_DIV) || (state == ST_HOLD);
  assign bus.res_valid = res_valid_r;
  assign bus.max_out   = max_r;
  assign bus.min_out   = min_r;
  assign bus.sum_out   = sum_r;
  assign bus.avg_out   = avg_r;

  lcd_div_seq #(.SW(SW)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (DIVISOR),
    .quotient (div_q),
    .done     (div_done)
  );
endmodule
`default_nettype wire

// File: tb/tb_lcd_win_stat.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_win_stat
// Purpose  : Randomized self-checking bench for lcd_win_stat against a simple
//            window-statistics reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_win_stat;
  import lcd_pkg::*;

  localparam int DW  = DW_DEF;
  localparam int PIX = PIX_NUM_DEF;
  localparam int GAP = GAP_MAX_DEF;
  localparam int SW  = SW_DEF;

  logic clk = 1'b0;
  logic reset_n;
  logic busy, win_err, overrun;

  lcd_win_stat_if #(.DW(DW), .SW(SW)) bus ();

  lcd_win_stat #(.DW(DW), .PIX_NUM(PIX), .SW(SW), .GAP_MAX(GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .win_err (win_err),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int werr_cnt = 0;
  int ovr_cnt  = 0;

  logic [DW-1:0] pix [0:15];
  int            gap_after [0:15];

  // Pulse counters sampled half a cycle after each edge.
  always @(negedge clk) begin
    if (win_err) werr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the PIX pixels of pix[] with gap_after[i] idle cycles after each.
  task automatic send_pixels();
    for (int i = 0; i < PIX; i++) begin
      bus.in_valid = 1'b1;
      bus.datain   = pix[i];
      tick();
      bus.in_valid = 1'b0;
      if (i < PIX - 1)
        for (int g = 0; g < gap_after[i]; g++) tick();
    end
  endtask

  // Send one window, check result, latency, stability and handshake.
  task automatic run_window(input string name, input int hold, input bit poke);
    int emax, emin, esum, eavg, lat, pokes, w0, o0;
    emax = 0; emin = (1 << DW) - 1; esum = 0;
    for (int i = 0; i < PIX; i++) begin
      if (int'(pix[i]) > emax) emax = int'(pix[i]);
      if (int'(pix[i]) < emin) emin = int'(pix[i]);
      esum += int'(pix[i]);
    end
    eavg  = esum / PIX;
    pokes = 0;
    w0    = werr_cnt;
    o0    = ovr_cnt;
    bus.res_ready = 1'b0;
    send_pixels();
    bus.res_ready = (hold == 0);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      if (poke && lat == 2) begin
        bus.in_valid = 1'b1;
        bus.datain   = DW'($urandom);
        pokes++;
      end
      tick();
      bus.in_valid = 1'b0;
      lat++;
    end
    chk({name, ".latency"}, lat, SW);
    chk({name, ".max"}, bus.max_out, emax);
    chk({name, ".min"}, bus.min_out, emin);
    chk({name, ".sum"}, bus.sum_out, esum);
    chk({name, ".avg"}, bus.avg_out, eavg);
    chk({name, ".busy"}, busy, 1);
    for (int h = 0; h < hold; h++) begin
      if (poke && (h % 2 == 0)) begin
        bus.in_valid = 1'b1;
        bus.datain   = DW'($urandom);
        pokes++;
      end
      tick();
      bus.in_valid = 1'b0;
      chk({name, ".hold_valid"}, bus.res_valid, 1);
      chk({name, ".hold_sum"}, bus.sum_out, esum);
      chk({name, ".hold_avg"}, bus.avg_out, eavg);
      chk({name, ".hold_busy"}, busy, 1);
    end
    if (hold > 0) begin
      bus.res_ready = 1'b1;
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.datain   = DW'($urandom);
        pokes++;
      end
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    chk({name, ".valid_drop"}, bus.res_valid, 0);
    tick();
    chk({name, ".valid_low"}, bus.res_valid, 0);
    chk({name, ".busy_idle"}, busy, 0);
    chk({name, ".keep_max"}, bus.max_out, emax);
    chk({name, ".overruns"}, ovr_cnt - o0, pokes);
    chk({name, ".no_winerr"}, werr_cnt - w0, 0);
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) gap_after[i] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, any_v;
    reset_n       = 1'b0;
    bus.datain    = '0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    clear_gaps();
    #1;
    chk("rst.valid", bus.res_valid, 0);
    chk("rst.sum", bus.sum_out, 0);
    chk("rst.busy", busy, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Ascending ramp, ready already high
    for (int i = 0; i < PIX; i++) pix[i] = DW'(10 * (i + 1));
    run_window("ramp", 0, 1'b0);

    // All full-scale pixels
    for (int i = 0; i < PIX; i++) pix[i] = '1;
    run_window("full", 0, 1'b0);

    // Tolerated gap of GAP-1 cycles after pixel 4
    for (int i = 0; i < PIX; i++) pix[i] = '0;
    pix[PIX-1] = DW'(8);
    gap_after[3] = GAP - 1;
    run_window("gap", 2, 1'b0);
    clear_gaps();

    // Abort after five pixels and GAP idle cycles
    w0 = werr_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.datain   = DW'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 1; k <= GAP; k++) begin
      tick();
      if (k == GAP - 1) chk("abort.early", win_err, 0);
    end
    chk("abort.pulse", win_err, 1);
    chk("abort.busy", busy, 0);
    tick();
    chk("abort.single", win_err, 0);
    chk("abort.count", werr_cnt - w0, 1);
    for (int i = 0; i < PIX; i++) pix[i] = DW'(7);
    run_window("after_abort", 0, 1'b0);

    // Long hold with overrun pixels during DIV, HOLD and the handshake edge
    for (int i = 0; i < PIX; i++) pix[i] = DW'($urandom);
    run_window("hold", 20, 1'b1);

    // Reset in the middle of the division
    w0 = werr_cnt;
    for (int i = 0; i < PIX; i++) pix[i] = DW'($urandom_range(1, 255));
    send_pixels();
    for (int k = 0; k < 5; k++) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst.valid", bus.res_valid, 0);
    chk("mid_rst.max", bus.max_out, 0);
    chk("mid_rst.sum", bus.sum_out, 0);
    chk("mid_rst.avg", bus.avg_out, 0);
    chk("mid_rst.busy", busy, 0);
    tick();
    reset_n = 1'b1;
    any_v = 0;
    for (int k = 0; k < SW + 4; k++) begin
      tick();
      if (bus.res_valid === 1'b1) any_v++;
    end
    chk("mid_rst.no_valid", any_v, 0);
    chk("mid_rst.no_winerr", werr_cnt - w0, 0);
    for (int i = 0; i < PIX; i++) pix[i] = DW'($urandom);
    run_window("post_rst", 1, 1'b0);

    // Random windows with tolerated gaps and random hold times
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < PIX; i++) begin
        case ($urandom_range(0, 3))
          0:       pix[i] = '0;
          1:       pix[i] = '1;
          default: pix[i] = DW'($urandom);
        endcase
        gap_after[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, GAP - 1)) : 0;
      end
      run_window($sformatf("rnd%0d", n), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end
    clear_gaps();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
